// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - output-stationary ROWS x COLS systolic matrix multiply engine
module systolic_matmul_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_K      = 256,
  localparam int KW        = $clog2(MAX_K + 1)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       acc_clear,
  input  logic [KW-1:0]                              k_len,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]            a_col,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]            b_row,
  output logic                                       busy,
  output logic                                       done,
  output logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]   acc_out
);

  // Drain length: the far corner PE sees the last beat ROWS+COLS-2 steps after it enters.
  localparam int FLUSH_CYC = ROWS + COLS - 2;
  localparam int FW        = $clog2(ROWS + COLS);
  localparam logic [KW-1:0] K_MAX      = KW'(MAX_K);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q;
  logic [KW-1:0]   beat_cnt_q;
  logic [FW-1:0]   flush_cnt_q;
  logic [KW-1:0]   k_eff;
  logic            launch;
  logic            step;
  logic            flushing;

  logic [DATA_WIDTH-1:0] a_edge   [ROWS];
  logic [DATA_WIDTH-1:0] b_edge   [COLS];
  logic [DATA_WIDTH-1:0] a_skew_q [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] b_skew_q [COLS][COLS];
  logic [DATA_WIDTH-1:0] a_in     [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_in     [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_q      [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_q      [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  prod     [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_q    [ROWS][COLS];

  assign k_eff    = (k_len > K_MAX) ? K_MAX : k_len;
  assign flushing = (state_q == FLUSH);

  // Controller: next state, handshake and array-advance decisions.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    step     = 1'b0;
    launch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = (k_eff == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          step = 1'b1;
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_d = (FLUSH_CYC == 0) ? DONE : FLUSH;
          end
        end
      end
      FLUSH: begin
        step = 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers: state, latched run length, beat and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        k_len_q     <= k_eff;
        beat_cnt_q  <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (step && state_q == LOAD) begin
          beat_cnt_q <= beat_cnt_q + KW'(1);
        end
        if (flushing) begin
          flush_cnt_q <= flush_cnt_q + FW'(1);
        end
      end
    end
  end

  // Edge lanes take the operand stream while loading and zeros while draining.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_edge
    assign a_edge[gi] = flushing ? '0 : a_col[gi];
  end
  for (genvar gj = 0; gj < COLS; gj++) begin : g_b_edge
    assign b_edge[gj] = flushing ? '0 : b_row[gj];
  end

  // PE operand routing: lane 0 direct, other edge lanes through their skew tap,
  // interior PEs from the left/upper neighbour's forwarding register.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      if (gj == 0) begin : g_a_src_edge
        if (gi == 0) begin : g_a_direct
          assign a_in[gi][gj] = a_edge[gi];
        end else begin : g_a_skewed
          assign a_in[gi][gj] = a_skew_q[gi][gi-1];
        end
      end else begin : g_a_src_pe
        assign a_in[gi][gj] = a_q[gi][gj-1];
      end

      if (gi == 0) begin : g_b_src_edge
        if (gj == 0) begin : g_b_direct
          assign b_in[gi][gj] = b_edge[gj];
        end else begin : g_b_skewed
          assign b_in[gi][gj] = b_skew_q[gj][gj-1];
        end
      end else begin : g_b_src_pe
        assign b_in[gi][gj] = b_q[gi-1][gj];
      end

      // Both factors sign-extended to the accumulator width; the low bits of the
      // product equal the exact signed product, which always fits.
      assign prod[gi][gj] =
        {{(ACC_WIDTH-DATA_WIDTH){a_in[gi][gj][DATA_WIDTH-1]}}, a_in[gi][gj]} *
        {{(ACC_WIDTH-DATA_WIDTH){b_in[gi][gj][DATA_WIDTH-1]}}, b_in[gi][gj]};

      assign acc_out[gi][gj] = acc_q[gi][gj];
    end
  end

  // Datapath: skew shift registers, PE forwarding registers and accumulators advance only on a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int n = 0; n < ROWS; n++) a_skew_q[i][n] <= '0;
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
      for (int j = 0; j < COLS; j++) begin
        for (int n = 0; n < COLS; n++) b_skew_q[j][n] <= '0;
      end
    end else if (launch) begin
      // A new run starts from an empty pipeline; accumulators clear only on request.
      for (int i = 0; i < ROWS; i++) begin
        for (int n = 0; n < ROWS; n++) a_skew_q[i][n] <= '0;
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          if (acc_clear) acc_q[i][j] <= '0;
        end
      end
      for (int j = 0; j < COLS; j++) begin
        for (int n = 0; n < COLS; n++) b_skew_q[j][n] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int n = ROWS - 1; n >= 1; n--) a_skew_q[i][n] <= a_skew_q[i][n-1];
        a_skew_q[i][0] <= a_edge[i];
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]   <= a_in[i][j];
          b_q[i][j]   <= b_in[i][j];
          acc_q[i][j] <= acc_q[i][j] + prod[i][j];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        for (int n = COLS - 1; n >= 1; n--) b_skew_q[j][n] <= b_skew_q[j][n-1];
        b_skew_q[j][0] <= b_edge[j];
      end
    end
  end

endmodule
